// File: rtl/lsu_mem_initiator_if.sv
// rtl/lsu_mem_initiator_if.sv - request/response and word-memory bus of the load/store unit
// slave is the LSU; master is the core plus data memory that surround it.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store unit driving a word-addressed data memory
// Sub-word loads are extracted from the read word; sub-word stores use read-modify-write.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  lsu_mem_initiator_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_error_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_write_data_q;
  logic              mem_write_q;
  logic              mem_read_q;

  logic              req_err_d;
  logic              req_needs_read_d;
  logic [DATA_W-1:0] load_word_d;
  logic [DATA_W-1:0] merge_word_d;

  function automatic logic [DATA_W-1:0] load_extract(
    input logic [2:0]        f3,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(
    input logic [2:0]        f3,
    input logic [1:0]        lane,
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_data
  );
    store_merge = old_word;
    if (f3[1:0] == 2'b00) begin
      store_merge[{lane, 3'b000} +: 8] = new_data[7:0];
    end else begin
      store_merge[{lane[1], 4'b0000} +: 16] = new_data[15:0];
    end
  endfunction

  // Reject illegal funct3 for the direction, then natural-alignment violations.
  always_comb begin
    req_err_d = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err_d = 1'b0;
      3'b001:  req_err_d = bus.req_addr[0];
      3'b010:  req_err_d = (bus.req_addr[1:0] != 2'b00);
      3'b100:  req_err_d = bus.req_write;
      3'b101:  req_err_d = bus.req_write | bus.req_addr[0];
      default: req_err_d = 1'b1;
    endcase
  end

  always_comb begin
    req_needs_read_d = !(bus.req_write && (bus.req_funct3 == 3'b010));
    load_word_d      = load_extract(funct3_q, addr_q[1:0], bus.mem_read_data);
    merge_word_d     = store_merge(funct3_q, addr_q[1:0], bus.mem_read_data, wdata_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      write_q          <= 1'b0;
      funct3_q         <= 3'd0;
      addr_q           <= '0;
      wdata_q          <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      resp_error_q     <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            funct3_q    <= bus.req_funct3;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else if (req_needs_read_d) begin
              state_q       <= RD;
              mem_read_q    <= 1'b1;
              mem_address_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end else begin
              state_q          <= WR;
              mem_write_q      <= 1'b1;
              mem_address_q    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_write_data_q <= bus.req_wdata;
            end
          end
        end
        RD: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            state_q          <= WR;
            mem_write_q      <= 1'b1;
            mem_address_q    <= {addr_q[ADDR_W-1:2], 2'b00};
            mem_write_data_q <= merge_word_d;
          end else begin
            state_q       <= RESP;
            resp_valid_q  <= 1'b1;
            resp_rdata_q  <= load_word_d;
            mem_address_q <= '0;
          end
        end
        WR: begin
          state_q          <= RESP;
          mem_write_q      <= 1'b0;
          mem_write_data_q <= '0;
          mem_address_q    <= '0;
          resp_valid_q     <= 1'b1;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_error_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_read       = mem_read_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - self-checking bench for lsu_mem_initiator
// Directed cases use fixed expectations; random traffic is checked against a word-memory model.
module tb_lsu_mem_initiator;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_fill = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  lsu_mem_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_write) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
  end

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic        exp_err;
    int          exp_lat;
  } dir_t;

  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_err(input bit w, input logic [2:0] f3, input logic [31:0] a);
    if (w && f3 > 3'd2) return 1'b1;
    if (!w && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    int unsigned sz;
    int unsigned sh;
    logic [31:0] v;
    sz = acc_size(f3);
    if (sz == 4) return word;
    sh = (a % 4) * 8;
    v = (word >> sh) & ((32'd1 << (8 * sz)) - 32'd1);
    if (!f3[2] && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] old_w, input logic [31:0] wd);
    int unsigned sz;
    int unsigned sh;
    logic [31:0] mask;
    sz = acc_size(f3);
    if (sz == 4) return wd;
    sh = (a % 4) * 8;
    mask = ((32'd1 << (8 * sz)) - 32'd1) << sh;
    return (old_w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int n_rd, output int n_wr, output int n_both, output int n_ready,
                        output logic [31:0] wdata_seen, output logic [31:0] addr_seen);
    lat = 0; rdata = '0; err = 1'b0; n_rd = 0; n_wr = 0; n_both = 0; n_ready = 0;
    wdata_seen = '0; addr_seen = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.mem_read) begin n_rd++; addr_seen = bus.mem_address; end
      if (bus.mem_write) begin n_wr++; wdata_seen = bus.mem_write_data; addr_seen = bus.mem_address; end
      if (bus.mem_read && bus.mem_write) n_both++;
      if (bus.req_ready) n_ready++;
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; err = bus.resp_error;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0 ||
        bus.resp_rdata !== 32'd0 || bus.mem_address !== 32'd0 || bus.mem_write_data !== 32'd0 ||
        bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b re=%b rd=%h ma=%h wd=%h mw=%b mr=%b required ready=1 rest 0",
               bus.req_ready, bus.resp_valid, bus.resp_error, bus.resp_rdata, bus.mem_address,
               bus.mem_write_data, bus.mem_write, bus.mem_read);
    end
    mem_fill = 1'b1;
    @(posedge clk);
    #1 mem_fill = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    dir_t tbl [13];
    int lat, n_rd, n_wr, n_both, n_ready;
    logic [31:0] rdata, wseen, aseen, word1;
    logic err;
    tbl[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 2};
    tbl[2]  = '{1'b1, 3'd0, 32'h12, 32'h000000A5, 32'h0,        32'hDEA5BEEF, 1'b0, 3};
    tbl[3]  = '{1'b0, 3'd0, 32'h12, 32'h0,        32'hFFFFFFA5, 32'h0,        1'b0, 2};
    tbl[4]  = '{1'b0, 3'd4, 32'h12, 32'h0,        32'h000000A5, 32'h0,        1'b0, 2};
    tbl[5]  = '{1'b1, 3'd2, 32'h14, 32'h0,        32'h0,        32'h0,        1'b0, 2};
    tbl[6]  = '{1'b1, 3'd1, 32'h16, 32'h00008001, 32'h0,        32'h80010000, 1'b0, 3};
    tbl[7]  = '{1'b0, 3'd1, 32'h16, 32'h0,        32'hFFFF8001, 32'h0,        1'b0, 2};
    tbl[8]  = '{1'b0, 3'd5, 32'h16, 32'h0,        32'h00008001, 32'h0,        1'b0, 2};
    tbl[9]  = '{1'b0, 3'd2, 32'h11, 32'h0,        32'h0,        32'h0,        1'b1, 1};
    tbl[10] = '{1'b0, 3'd1, 32'h13, 32'h0,        32'h0,        32'h0,        1'b1, 1};
    tbl[11] = '{1'b1, 3'd2, 32'h06, 32'h12345678, 32'h0,        32'h0,        1'b1, 1};
    tbl[12] = '{1'b0, 3'd3, 32'h20, 32'h0,        32'h0,        32'h0,        1'b1, 1};
    word1 = mem[1];
    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].w, tbl[i].f3, tbl[i].addr, tbl[i].wd, lat, rdata, err, n_rd, n_wr, n_both, n_ready, wseen, aseen);
      checks++;
      if (lat != tbl[i].exp_lat || rdata !== tbl[i].exp_rdata || err !== tbl[i].exp_err) begin
        errors++;
        $display("FAIL directed_resp[%0d]: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                 i, lat, rdata, err, tbl[i].exp_lat, tbl[i].exp_rdata, tbl[i].exp_err);
      end
      checks++;
      if (tbl[i].exp_err ? (n_rd + n_wr != 0) :
          (n_both != 0 || (tbl[i].w && (n_wr != 1 || wseen !== tbl[i].exp_wdata)) || (!tbl[i].w && n_wr != 0))) begin
        errors++;
        $display("FAIL directed_strobes[%0d]: rd=%0d wr=%0d both=%0d wdata=%h required wdata=%h",
                 i, n_rd, n_wr, n_both, wseen, tbl[i].exp_wdata);
      end
      if (tbl[i].w && !tbl[i].exp_err)
        ref_mem[tbl[i].addr[7:2]] = ref_store(tbl[i].f3, tbl[i].addr, ref_mem[tbl[i].addr[7:2]], tbl[i].wd);
    end
    checks++;
    if (mem[4] !== 32'hDEA5BEEF || mem[5] !== 32'h80010000 || mem[1] !== word1) begin
      errors++;
      $display("FAIL directed_memory: w4=%h w5=%h w1=%h required w4=dea5beef w5=80010000 w1=%h",
               mem[4], mem[5], mem[1], word1);
    end
  endtask

  task automatic test_random(input int n);
    int lat, n_rd, n_wr, n_both, n_ready, exp_lat, exp_rd, exp_wr;
    logic [31:0] rdata, wseen, aseen, addr, wd, exp_rdata, exp_word;
    logic err, w, exp_err;
    logic [2:0] f3;
    logic [2:0] load_f3 [5];
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int t = 0; t < n; t++) begin
      w = 1'($urandom % 2);
      if ($urandom % 4 == 0) f3 = 3'($urandom % 8);
      else f3 = w ? 3'($urandom % 3) : load_f3[$urandom % 5];
      addr = $urandom_range(0, 255);
      if ($urandom % 4 != 0) addr = addr & ~(acc_size(f3) - 1);
      wd = $urandom;
      exp_err   = ref_err(w, f3, addr);
      exp_word  = ref_mem[addr[7:2]];
      exp_rdata = 32'd0;
      if (!exp_err && !w) exp_rdata = ref_load(f3, addr, exp_word);
      if (!exp_err && w) exp_word = ref_store(f3, addr, exp_word, wd);
      exp_lat = exp_err ? 1 : (w && f3 != 3'd2) ? 3 : 2;
      exp_rd  = (exp_err || (w && f3 == 3'd2)) ? 0 : 1;
      exp_wr  = (!exp_err && w) ? 1 : 0;
      do_req(w, f3, addr, wd, lat, rdata, err, n_rd, n_wr, n_both, n_ready, wseen, aseen);
      checks++;
      if (lat != exp_lat || rdata !== exp_rdata || err !== exp_err) begin
        errors++;
        $display("FAIL random_resp[%0d]: w=%b f3=%0d addr=%h lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                 t, w, f3, addr, lat, rdata, err, exp_lat, exp_rdata, exp_err);
      end
      checks++;
      if (n_rd != exp_rd || n_wr != exp_wr || n_both != 0 || n_ready != 0 ||
          (exp_wr == 1 && wseen !== exp_word) || (exp_rd + exp_wr > 0 && aseen !== (addr & ~32'd3))) begin
        errors++;
        $display("FAIL random_strobes[%0d]: rd=%0d wr=%0d both=%0d busy_ready=%0d wdata=%h addr=%h required rd=%0d wr=%0d wdata=%h addr=%h",
                 t, n_rd, n_wr, n_both, n_ready, wseen, aseen, exp_rd, exp_wr, exp_word, addr & ~32'd3);
      end
      ref_mem[addr[7:2]] = exp_word;
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem[addr[7:2]] !== exp_word ||
          bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL random_after[%0d]: rv=%b ready=%b word=%h required rv=0 ready=1 word=%h",
                 t, bus.resp_valid, bus.req_ready, mem[addr[7:2]], exp_word);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2;
    a1 = ($urandom % 64) * 4;
    a2 = ($urandom % 64) * 4;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = a1;
    @(posedge clk);
    #1 bus.req_addr = a2;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rd1: ready=%b mem_read=%b required ready=0 mem_read=1", bus.req_ready, bus.mem_read);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_rdata !== ref_mem[a1[7:2]]) begin
      errors++;
      $display("FAIL b2b_resp1: ready=%b rv=%b rdata=%h required ready=0 rv=1 rdata=%h",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, ref_mem[a1[7:2]]);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b rv=%b required ready=1 rv=0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_address !== a2) begin
      errors++;
      $display("FAIL b2b_rd2: ready=%b mem_read=%b addr=%h required ready=0 mem_read=1 addr=%h",
               bus.req_ready, bus.mem_read, bus.mem_address, a2);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== ref_mem[a2[7:2]] || bus.resp_error !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp2: rv=%b rdata=%h err=%b required rv=1 rdata=%h err=0",
               bus.resp_valid, bus.resp_rdata, bus.resp_error, ref_mem[a2[7:2]]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old_w;
    int pulses;
    int lat, n_rd, n_wr, n_both, n_ready;
    logic [31:0] rdata, wseen, aseen;
    logic err;
    old_w = mem[4];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h12; bus.req_wdata = 32'h0000005A;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_reached: mem_write=%b required 1", bus.mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || {bus.resp_valid, bus.resp_error, bus.mem_write, bus.mem_read} !== 4'b0 ||
        bus.resp_rdata !== 32'd0 || bus.mem_address !== 32'd0 || bus.mem_write_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_wr_outputs: ready=%b rv=%b mw=%b mr=%b ma=%h wd=%h required ready=1 rest 0",
               bus.req_ready, bus.resp_valid, bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_write_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem[4] !== old_w || old_w !== ref_mem[4]) begin
      errors++;
      $display("FAIL rst_wr_memory: word=%h required %h", mem[4], ref_mem[4]);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.resp_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_no_resp: pulses=%0d ready=%b required pulses=0 ready=1", pulses, bus.req_ready);
    end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, n_ready, wseen, aseen);
    checks++;
    if (lat != 2 || rdata !== ref_mem[4] || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_recover: lat=%0d rdata=%h err=%b required lat=2 rdata=%h err=0",
               lat, rdata, err, ref_mem[4]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(120);
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
